param_sync_fifo: RTL and testbench

- Parametrised single-clock FIFO that replaces the fixed 4-bit inFIFO/outFIFO pair between the host nibble interface, the coder, and the decoder/CORDIC output path.
- Adds generic width and depth, programmable almost-full/almost-empty thresholds, a fill-level output, a synchronous flush, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.

---
 rtl/param_sync_fifo.sv | 163 ++++++++++++++++
 tb/tb_param_sync_fifo.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with programmable depth/width, threshold flags, sticky
// error flags, synchronous flush and a selectable first-word-fall-through read port.
module param_sync_fifo #(
  parameter int DATA_WIDTH   = 4,
  parameter int DEPTH        = 16,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 4,
  parameter int FWFT         = 0
) (
  input  logic                    inClock,
  input  logic                    inReset,
  input  logic                    inClear,
  input  logic [DATA_WIDTH-1:0]   inData,
  input  logic                    inWriteEnable,
  input  logic                    inReadEnable,
  output logic [DATA_WIDTH-1:0]   outData,
  output logic                    outValid,
  output logic                    outEmpty,
  output logic                    outFull,
  output logic                    outAlmostEmpty,
  output logic                    outAlmostFull,
  output logic [$clog2(DEPTH):0]  outCount,
  output logic                    outOverflow,
  output logic                    outUnderflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of 2 and at least 2");
  end
  if ((AFULL_LEVEL < 1) || (AFULL_LEVEL > DEPTH)) begin : g_bad_afull
    $error("param_sync_fifo: AFULL_LEVEL must be in 1..DEPTH");
  end
  if ((AEMPTY_LEVEL < 0) || (AEMPTY_LEVEL > DEPTH - 1)) begin : g_bad_aempty
    $error("param_sync_fifo: AEMPTY_LEVEL must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  empty_s, full_s;
  logic                  rd_acc_s, wr_acc_s, mem_we_s;

  // Status decodes of the count register.
  always_comb begin
    empty_s = (count_q == {CW{1'b0}});
    full_s  = (count_q == CW'(DEPTH));
  end

  // Accept rules, pointer/count/flag next-state and registered read data.
  always_comb begin
    rd_acc_s = inReadEnable & ~empty_s;
    wr_acc_s = inWriteEnable & (~full_s | rd_acc_s);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    mem_we_s = 1'b0;
    if (inClear) begin
      // Flush wins over any read or write presented in the same cycle.
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
      mem_we_s = 1'b0;
    end else begin
      mem_we_s = wr_acc_s;
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        rdata_d  = mem_q[rd_ptr_q];
        valid_d  = 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q;
        rdata_d  = rdata_q;
        valid_d  = 1'b0;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (inWriteEnable && !wr_acc_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
      if (inReadEnable && !rd_acc_s) begin
        udf_d = 1'b1;
      end else begin
        udf_d = udf_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      rdata_q  <= {DATA_WIDTH{1'b0}};
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge inClock) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= inData;
    end
  end

  // Read port: registered data, or the head word shown directly in FWFT mode.
  always_comb begin
    if (FWFT != 0) begin
      outValid = ~empty_s;
      if (empty_s) begin
        outData = {DATA_WIDTH{1'b0}};
      end else begin
        outData = mem_q[rd_ptr_q];
      end
    end else begin
      outValid = valid_q;
      outData  = rdata_q;
    end
  end

  assign outEmpty       = empty_s;
  assign outFull        = full_s;
  assign outAlmostEmpty = (count_q <= CW'(AEMPTY_LEVEL));
  assign outAlmostFull  = (count_q >= CW'(AFULL_LEVEL));
  assign outCount       = count_q;
  assign outOverflow    = ovf_q;
  assign outUnderflow   = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed, table-driven bench for param_sync_fifo: a registered-read DEPTH=8
// instance driven from a vector table, plus a small FWFT instance.
module tb_param_sync_fifo;

  typedef struct {
    logic       we;
    logic       re;
    logic       clr;
    logic [3:0] din;
    int         cnt;
    logic       valid;
    logic [3:0] data;
    logic       chkd;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       a_clr = 1'b0, a_we = 1'b0, a_re = 1'b0;
  logic [3:0] a_din = 4'h0;
  logic [3:0] a_dout;
  logic       a_valid, a_empty, a_full, a_aempty, a_afull, a_ovf, a_udf;
  logic [3:0] a_count;

  logic       b_clr = 1'b0, b_we = 1'b0, b_re = 1'b0;
  logic [3:0] b_din = 4'h0;
  logic [3:0] b_dout;
  logic       b_valid, b_empty, b_full, b_aempty, b_afull, b_ovf, b_udf;
  logic [2:0] b_count;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_WIDTH(4), .DEPTH(8), .AFULL_LEVEL(6), .AEMPTY_LEVEL(2), .FWFT(0)) u_a (
    .inClock(clk), .inReset(rst_n), .inClear(a_clr), .inData(a_din),
    .inWriteEnable(a_we), .inReadEnable(a_re), .outData(a_dout), .outValid(a_valid),
    .outEmpty(a_empty), .outFull(a_full), .outAlmostEmpty(a_aempty), .outAlmostFull(a_afull),
    .outCount(a_count), .outOverflow(a_ovf), .outUnderflow(a_udf)
  );

  param_sync_fifo #(.DATA_WIDTH(4), .DEPTH(4), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1), .FWFT(1)) u_b (
    .inClock(clk), .inReset(rst_n), .inClear(b_clr), .inData(b_din),
    .inWriteEnable(b_we), .inReadEnable(b_re), .outData(b_dout), .outValid(b_valid),
    .outEmpty(b_empty), .outFull(b_full), .outAlmostEmpty(b_aempty), .outAlmostFull(b_afull),
    .outCount(b_count), .outOverflow(b_ovf), .outUnderflow(b_udf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic we, input logic re, input logic clr, input logic [3:0] din,
                              input int cnt, input logic valid, input logic [3:0] data,
                              input logic chkd, input logic ovf, input logic udf);
    vec_t v;
    v.we = we; v.re = re; v.clr = clr; v.din = din; v.cnt = cnt;
    v.valid = valid; v.data = data; v.chkd = chkd; v.ovf = ovf; v.udf = udf;
    vecs.push_back(v);
  endfunction

  task automatic check_a_flags(input string tag, input int cnt, input logic ovf, input logic udf);
    chk({tag, " count"}, 32'(a_count), 32'(cnt));
    chk({tag, " empty"}, 32'(a_empty), 32'(cnt == 0));
    chk({tag, " full"}, 32'(a_full), 32'(cnt == 8));
    chk({tag, " aempty"}, 32'(a_aempty), 32'(cnt <= 2));
    chk({tag, " afull"}, 32'(a_afull), 32'(cnt >= 6));
    chk({tag, " ovf"}, 32'(a_ovf), 32'(ovf));
    chk({tag, " udf"}, 32'(a_udf), 32'(udf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] rv [4];
    rv[0] = 4'h1; rv[1] = 4'h4; rv[2] = 4'h9; rv[3] = 4'hD;

    // Fill/drain four rounds so the pointers wrap.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) add(1'b1, 1'b0, 1'b0, rv[k], k + 1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) add(1'b0, 1'b1, 1'b0, 4'h0, 3 - k, 1'b1, rv[k], 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 4'h0, 0, 1'b0, 4'hD, 1'b1, 1'b0, 1'b0);
    end
    // Full boundary, overflow, read+write while full, then drain.
    for (int k = 0; k < 8; k++) add(1'b1, 1'b0, 1'b0, 4'(k + 3), k + 1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'hE, 8, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 4'hF, 8, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) add(1'b0, 1'b1, 1'b0, 4'h0, 8 - k, 1'b1, 4'(k + 3), 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0);
    // Underflow on empty, flush, then read+write on empty.
    add(1'b0, 1'b1, 1'b0, 4'h0, 0, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 4'h0, 0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 4'h6, 1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'h0, 0, 1'b1, 4'h6, 1'b1, 1'b0, 1'b1);
    // Fill to 5, flush together with a write.
    for (int k = 0; k < 5; k++) add(1'b1, 1'b0, 1'b0, 4'(k + 1), k + 1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b1, 4'h7, 0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'h0, 0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    // Fill to 3 ahead of the asynchronous reset sequence.
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 1'b0, 4'(k + 2), k + 1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Reset held for 5 clocks.
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check_a_flags("reset", 0, 1'b0, 1'b0);
    chk("reset valid", 32'(a_valid), 32'd0);
    chk("reset data", 32'(a_dout), 32'd0);
    chk("reset b empty", 32'(b_empty), 32'd1);

    // FWFT instance: write becomes visible without a read, read acknowledges.
    b_we = 1'b1; b_din = 4'hA;
    @(posedge clk); #1;
    b_we = 1'b0; b_din = 4'h0;
    chk("fwft empty after write", 32'(b_empty), 32'd0);
    chk("fwft data after write", 32'(b_dout), 32'hA);
    chk("fwft valid after write", 32'(b_valid), 32'd1);
    chk("fwft count after write", 32'(b_count), 32'd1);
    @(posedge clk); #1;
    chk("fwft data held", 32'(b_dout), 32'hA);
    b_re = 1'b1;
    @(posedge clk); #1;
    b_re = 1'b0;
    chk("fwft empty after read", 32'(b_empty), 32'd1);
    chk("fwft valid after read", 32'(b_valid), 32'd0);
    chk("fwft udf", 32'(b_udf), 32'd0);

    // Table-driven vectors on the registered-read instance.
    for (int i = 0; i < vecs.size(); i++) begin
      a_we = vecs[i].we; a_re = vecs[i].re; a_clr = vecs[i].clr; a_din = vecs[i].din;
      @(posedge clk); #1;
      a_we = 1'b0; a_re = 1'b0; a_clr = 1'b0; a_din = 4'h0;
      check_a_flags($sformatf("v%0d", i), vecs[i].cnt, vecs[i].ovf, vecs[i].udf);
      chk($sformatf("v%0d valid", i), 32'(a_valid), 32'(vecs[i].valid));
      if (vecs[i].chkd) chk($sformatf("v%0d data", i), 32'(a_dout), 32'(vecs[i].data));
    end

    // In-flight read, then asynchronous reset between clock edges.
    a_re = 1'b1;
    @(posedge clk); #1;
    a_re = 1'b0;
    chk("pre-reset valid", 32'(a_valid), 32'd1);
    chk("pre-reset data", 32'(a_dout), 32'h2);
    chk("pre-reset count", 32'(a_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check_a_flags("async reset", 0, 1'b0, 1'b0);
    chk("async reset valid", 32'(a_valid), 32'd0);
    chk("async reset data", 32'(a_dout), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_a_flags("after release", 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
